// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note events to a voice table and
// streams the table one slot per cycle on every sample tick.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_BITS  = 7,
    parameter int unsigned AGE_BITS   = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            note_valid_in,
    output logic                            note_ready_out,
    input  logic                            note_on_in,
    input  logic [NOTE_BITS-1:0]            note_in,
    input  logic                            sample_tick_in,
    output logic                            slot_valid_out,
    output logic [$clog2(NUM_VOICES)-1:0]   slot_voice_out,
    output logic [NOTE_BITS-1:0]            slot_note_out,
    output logic                            slot_active_out,
    output logic                            slot_last_out,
    output logic [$clog2(NUM_VOICES):0]     active_count_out,
    output logic                            steal_out,
    output logic                            overrun_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_COMMIT
    } state_e;

    state_e state_q, state_d;
    logic   ready_q, ready_d;
    logic   ev_on_q, ev_on_d;
    logic [NOTE_BITS-1:0] ev_note_q, ev_note_d;
    logic [IDX_W-1:0]     search_idx_q, search_idx_d;

    logic                 match_found_q, match_found_d;
    logic [IDX_W-1:0]     match_idx_q, match_idx_d;
    logic                 free_found_q, free_found_d;
    logic [IDX_W-1:0]     free_idx_q, free_idx_d;
    logic [IDX_W-1:0]     old_idx_q, old_idx_d;
    logic [AGE_BITS-1:0]  old_age_q, old_age_d;

    logic [NUM_VOICES-1:0]                active_q, active_d;
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0][AGE_BITS-1:0]  stamp_q, stamp_d;
    logic [AGE_BITS-1:0]                  age_q, age_d;
    logic [CNT_W-1:0]                     count_q, count_d;
    logic                                 steal_q, steal_d;

    logic                 slot_valid_q, slot_valid_d;
    logic [IDX_W-1:0]     slot_voice_q, slot_voice_d;
    logic [NOTE_BITS-1:0] slot_note_q, slot_note_d;
    logic                 slot_active_q, slot_active_d;
    logic                 slot_last_q, slot_last_d;
    logic                 overrun_q, overrun_d;

    logic [AGE_BITS-1:0]  cur_age;
    logic [IDX_W-1:0]     tgt_idx;

    // Event FSM: linear search over the table, then a single-cycle commit.
    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        search_idx_d  = search_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        active_d      = active_q;
        note_d        = note_q;
        stamp_d       = stamp_q;
        age_d         = age_q;
        steal_d       = 1'b0;
        tgt_idx       = '0;
        cur_age       = age_q - stamp_q[search_idx_q];

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (note_valid_in && ready_q) begin
                    ready_d      = 1'b0;
                    ev_on_d      = note_on_in;
                    ev_note_d    = note_in;
                    search_idx_d = '0;
                    state_d      = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (search_idx_q == '0) begin
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    old_idx_d     = '0;
                    old_age_d     = cur_age;
                end else if (cur_age > old_age_q) begin
                    old_idx_d = search_idx_q;
                    old_age_d = cur_age;
                end
                if (!match_found_d && active_q[search_idx_q] &&
                    (note_q[search_idx_q] == ev_note_q)) begin
                    match_found_d = 1'b1;
                    match_idx_d   = search_idx_q;
                end
                if (!free_found_d && !active_q[search_idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = search_idx_q;
                end
                if (search_idx_q == LAST_IDX) begin
                    state_d = ST_COMMIT;
                    // Registered so the pulse lines up with the commit cycle.
                    steal_d = ev_on_q && !match_found_d && !free_found_d;
                end else begin
                    search_idx_d = search_idx_q + IDX_W'(1);
                end
            end
            ST_COMMIT: begin
                if (ev_on_q) begin
                    if (match_found_q) begin
                        tgt_idx = match_idx_q;
                    end else if (free_found_q) begin
                        tgt_idx = free_idx_q;
                    end else begin
                        tgt_idx = old_idx_q;
                    end
                    active_d[tgt_idx] = 1'b1;
                    note_d[tgt_idx]   = ev_note_q;
                    stamp_d[tgt_idx]  = age_q;
                    age_d             = age_q + AGE_BITS'(1);
                end else if (match_found_q) begin
                    active_d[match_idx_q] = 1'b0;
                end
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        count_d = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            count_d = count_d + CNT_W'(active_d[i]);
        end
    end

    // Scan sequencer; slot data samples the next-state table so a commit is
    // visible in the very next emitted slot.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_voice_d = slot_voice_q;
        slot_last_d  = slot_last_q;
        overrun_d    = sample_tick_in && slot_valid_q;

        if (slot_valid_q) begin
            if (slot_last_q) begin
                slot_valid_d = 1'b0;
                slot_last_d  = 1'b0;
            end else begin
                slot_voice_d = slot_voice_q + IDX_W'(1);
                slot_last_d  = ((slot_voice_q + IDX_W'(1)) == LAST_IDX);
            end
        end else if (sample_tick_in) begin
            slot_valid_d = 1'b1;
            slot_voice_d = '0;
            slot_last_d  = 1'b0;
        end

        slot_active_d = slot_valid_d && active_d[slot_voice_d];
        slot_note_d   = slot_valid_d ? note_d[slot_voice_d] : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            search_idx_q  <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            active_q      <= '0;
            note_q        <= '0;
            stamp_q       <= '0;
            age_q         <= '0;
            count_q       <= '0;
            steal_q       <= 1'b0;
            slot_valid_q  <= 1'b0;
            slot_voice_q  <= '0;
            slot_note_q   <= '0;
            slot_active_q <= 1'b0;
            slot_last_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            search_idx_q  <= search_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            active_q      <= active_d;
            note_q        <= note_d;
            stamp_q       <= stamp_d;
            age_q         <= age_d;
            count_q       <= count_d;
            steal_q       <= steal_d;
            slot_valid_q  <= slot_valid_d;
            slot_voice_q  <= slot_voice_d;
            slot_note_q   <= slot_note_d;
            slot_active_q <= slot_active_d;
            slot_last_q   <= slot_last_d;
            overrun_q     <= overrun_d;
        end
    end

    assign note_ready_out   = ready_q;
    assign slot_valid_out   = slot_valid_q;
    assign slot_voice_out   = slot_voice_q;
    assign slot_note_out    = slot_note_q;
    assign slot_active_out  = slot_active_q;
    assign slot_last_out    = slot_last_q;
    assign active_count_out = count_q;
    assign steal_out        = steal_q;
    assign overrun_out      = overrun_q;

endmodule
